// File: rtl/wbp_rr_arbiter.sv
// Two-master, one-slave Wishbone pipelined arbiter with round-robin ownership.
// Each master keeps the bus for its whole cycle, and acks/errors go only to the owner.
//   state | meaning
//   IDLE  | no owner, both masters stalled
//   OWN_A | master A owns the downstream port
//   OWN_B | master B owns the downstream port
module wbp_rr_arbiter #(
  parameter int AW       = 12,
  parameter int DW       = 32,
  parameter int LGMAXOUT = 4
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_acyc,
  input  logic            i_astb,
  input  logic            i_awe,
  input  logic [AW-1:0]   i_aaddr,
  input  logic [DW-1:0]   i_adata,
  input  logic [DW/8-1:0] i_asel,
  output logic            o_astall,
  output logic            o_aack,
  output logic            o_aerr,
  output logic [DW-1:0]   o_adata,
  input  logic            i_bcyc,
  input  logic            i_bstb,
  input  logic            i_bwe,
  input  logic [AW-1:0]   i_baddr,
  input  logic [DW-1:0]   i_bdata,
  input  logic [DW/8-1:0] i_bsel,
  output logic            o_bstall,
  output logic            o_back,
  output logic            o_berr,
  output logic [DW-1:0]   o_bdata,
  output logic            o_mcyc,
  output logic            o_mstb,
  output logic            o_mwe,
  output logic [AW-1:0]   o_maddr,
  output logic [DW-1:0]   o_mdata,
  output logic [DW/8-1:0] o_msel,
  input  logic            i_mstall,
  input  logic            i_mack,
  input  logic            i_merr,
  input  logic [DW-1:0]   i_mdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN_A = 2'd1, OWN_B = 2'd2} state_t;

  state_t              state_q, state_d;
  logic                last_b_q, last_b_d;
  logic [LGMAXOUT-1:0] cnt_q, cnt_d;
  logic                a_req, b_req, full, accept, own_cyc;

  always_comb begin
    a_req    = i_acyc && i_astb;
    b_req    = i_bcyc && i_bstb;
    full     = (cnt_q == {LGMAXOUT{1'b1}});
    own_cyc  = 1'b0;
    o_mcyc   = 1'b0;
    o_mstb   = 1'b0;
    o_mwe    = 1'b0;
    o_maddr  = '0;
    o_mdata  = '0;
    o_msel   = '0;
    o_astall = 1'b1;
    o_bstall = 1'b1;
    o_aack   = 1'b0;
    o_back   = 1'b0;
    o_aerr   = 1'b0;
    o_berr   = 1'b0;
    o_adata  = i_mdata;
    o_bdata  = i_mdata;

    case (state_q)
      OWN_A: begin
        own_cyc  = i_acyc;
        o_mcyc   = i_acyc;
        o_mstb   = i_acyc && i_astb && !full;
        o_mwe    = i_awe;
        o_maddr  = i_aaddr;
        o_mdata  = i_adata;
        o_msel   = i_asel;
        o_astall = i_mstall || full;
        o_aack   = i_mack && i_acyc;
        o_aerr   = i_merr && i_acyc;
      end
      OWN_B: begin
        own_cyc  = i_bcyc;
        o_mcyc   = i_bcyc;
        o_mstb   = i_bcyc && i_bstb && !full;
        o_mwe    = i_bwe;
        o_maddr  = i_baddr;
        o_mdata  = i_bdata;
        o_msel   = i_bsel;
        o_bstall = i_mstall || full;
        o_back   = i_mack && i_bcyc;
        o_berr   = i_merr && i_bcyc;
      end
      default: ;
    endcase

    accept   = o_mstb && !i_mstall;
    state_d  = state_q;
    last_b_d = last_b_q;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE: begin
        // On a tie, the master that did not own the bus last wins.
        if (a_req && (!b_req || last_b_q)) state_d = OWN_A;
        else if (b_req)                    state_d = OWN_B;
      end
      OWN_A, OWN_B: begin
        if (!own_cyc) begin
          // Owner aborted: whatever is still in flight is forgotten.
          cnt_d    = '0;
          last_b_d = (state_q == OWN_B);
          if (state_q == OWN_A) state_d = b_req ? OWN_B : IDLE;
          else                  state_d = a_req ? OWN_A : IDLE;
        end else if (i_merr) begin
          cnt_d = '0;
        end else if (accept && !i_mack) begin
          cnt_d = cnt_q + 1'b1;
        end else if (!accept && i_mack && (cnt_q != '0)) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_b_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_b_q <= last_b_d;
    end
  end

endmodule

// File: tb/tb_wbp_rr_arbiter.sv
// Scoreboard bench for wbp_rr_arbiter: a directed warm-up followed by random traffic,
// with every cycle's expected outputs produced by a reference model of the arbiter.
module tb_wbp_rr_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int LG = 2;
  localparam int MAXOUT = (1 << LG) - 1;

  logic          clk = 1'b0;
  logic          i_reset_n;
  logic          i_acyc, i_astb, i_awe, i_bcyc, i_bstb, i_bwe;
  logic [AW-1:0] i_aaddr, i_baddr;
  logic [DW-1:0] i_adata, i_bdata, i_mdata;
  logic [SW-1:0] i_asel, i_bsel;
  logic          i_mstall, i_mack, i_merr;
  logic          o_astall, o_aack, o_aerr, o_bstall, o_back, o_berr;
  logic [DW-1:0] o_adata, o_bdata, o_mdata;
  logic          o_mcyc, o_mstb, o_mwe;
  logic [AW-1:0] o_maddr;
  logic [SW-1:0] o_msel;

  always #5 clk = ~clk;

  wbp_rr_arbiter #(.AW(AW), .DW(DW), .LGMAXOUT(LG)) dut (
    .i_clk(clk), .i_reset_n(i_reset_n),
    .i_acyc(i_acyc), .i_astb(i_astb), .i_awe(i_awe), .i_aaddr(i_aaddr),
    .i_adata(i_adata), .i_asel(i_asel), .o_astall(o_astall), .o_aack(o_aack),
    .o_aerr(o_aerr), .o_adata(o_adata),
    .i_bcyc(i_bcyc), .i_bstb(i_bstb), .i_bwe(i_bwe), .i_baddr(i_baddr),
    .i_bdata(i_bdata), .i_bsel(i_bsel), .o_bstall(o_bstall), .o_back(o_back),
    .o_berr(o_berr), .o_bdata(o_bdata),
    .o_mcyc(o_mcyc), .o_mstb(o_mstb), .o_mwe(o_mwe), .o_maddr(o_maddr),
    .o_mdata(o_mdata), .o_msel(o_msel), .i_mstall(i_mstall), .i_mack(i_mack),
    .i_merr(i_merr), .i_mdata(i_mdata)
  );

  typedef struct packed {
    logic          mcyc, mstb, mwe;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mdata;
    logic [SW-1:0] msel;
    logic          astall, bstall, aack, back, aerr, berr;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;

  // Reference model: who owns the bus (0 none, 1 A, 2 B), who owned it last, transfers in flight.
  int own = 0;
  int last = 2;
  int cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic acyc, input logic astb, input logic bcyc, input logic bstb,
                       input logic mstall, input logic mack, input logic merr,
                       input logic rstn, input logic [DW-1:0] mdat);
    exp_t e;
    logic xcyc, xstb, full, acc;
    int   other, pending;
    logic req [1:2];
    @(negedge clk);
    i_acyc = acyc;  i_astb = astb && acyc;
    i_bcyc = bcyc;  i_bstb = bstb && bcyc;
    i_awe = 1'($urandom);  i_bwe = 1'($urandom);
    i_aaddr = AW'($urandom);  i_baddr = AW'($urandom);
    i_adata = $urandom;  i_bdata = $urandom;
    i_asel = SW'($urandom);  i_bsel = SW'($urandom);
    i_mstall = mstall;  i_mack = mack;  i_merr = merr;
    i_reset_n = rstn;  i_mdata = mdat;
    #1;
    req[1] = i_acyc && i_astb;
    req[2] = i_bcyc && i_bstb;
    e = '0;
    e.astall = 1'b1;
    e.bstall = 1'b1;
    e.rdata = i_mdata;
    xcyc = 1'b0;
    xstb = 1'b0;
    full = (cnt == MAXOUT);
    if (own == 1) begin
      xcyc = i_acyc;  xstb = i_astb;
      e.mwe = i_awe;  e.maddr = i_aaddr;  e.mdata = i_adata;  e.msel = i_asel;
      e.astall = i_mstall || full;
      e.aack = i_mack && xcyc;
      e.aerr = i_merr && xcyc;
    end else if (own == 2) begin
      xcyc = i_bcyc;  xstb = i_bstb;
      e.mwe = i_bwe;  e.maddr = i_baddr;  e.mdata = i_bdata;  e.msel = i_bsel;
      e.bstall = i_mstall || full;
      e.back = i_mack && xcyc;
      e.berr = i_merr && xcyc;
    end
    e.mcyc = xcyc;
    e.mstb = xcyc && xstb && !full;
    sb_q.push_back(e);

    if (!i_reset_n) begin
      own = 0;  cnt = 0;  last = 2;
    end else if (own == 0) begin
      if (req[1] && req[2]) own = (last == 1) ? 2 : 1;
      else if (req[1])      own = 1;
      else if (req[2])      own = 2;
    end else if (!xcyc) begin
      other = 3 - own;
      last = own;
      cnt = 0;
      own = req[other] ? other : 0;
    end else if (i_merr) begin
      cnt = 0;
    end else begin
      acc = e.mstb && !i_mstall;
      pending = cnt + int'(acc) - int'(i_mack);
      cnt = (pending < 0) ? 0 : pending;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("mcyc", 64'(o_mcyc), 64'(e.mcyc));
        chk("mstb", 64'(o_mstb), 64'(e.mstb));
        chk("mwe", 64'(o_mwe), 64'(e.mwe));
        chk("maddr", 64'(o_maddr), 64'(e.maddr));
        chk("mdata", 64'(o_mdata), 64'(e.mdata));
        chk("msel", 64'(o_msel), 64'(e.msel));
        chk("astall", 64'(o_astall), 64'(e.astall));
        chk("bstall", 64'(o_bstall), 64'(e.bstall));
        chk("aack", 64'(o_aack), 64'(e.aack));
        chk("back", 64'(o_back), 64'(e.back));
        chk("aerr", 64'(o_aerr), 64'(e.aerr));
        chk("berr", 64'(o_berr), 64'(e.berr));
        if (e.aack) chk("adata", 64'(o_adata), 64'(e.rdata));
        if (e.back) chk("bdata", 64'(o_bdata), 64'(e.rdata));
      end
    end
  end

  initial begin : stimulus
    logic ac, bc, as, bs, ms, mk, me, rn;
    int   ph;
    i_reset_n = 1'b0;
    i_acyc = 0; i_astb = 0; i_awe = 0; i_aaddr = '0; i_adata = '0; i_asel = '0;
    i_bcyc = 0; i_bstb = 0; i_bwe = 0; i_baddr = '0; i_bdata = '0; i_bsel = '0;
    i_mstall = 0; i_mack = 0; i_merr = 0; i_mdata = '0;
    @(posedge clk);

    // single read from A, acked with a known word
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 1, 0, 1, 32'hDEADBEEF);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    // simultaneous requests, hand-over, then a fresh tie
    drive(1, 1, 1, 1, 0, 0, 0, 1, 0);
    drive(1, 0, 1, 1, 0, 0, 0, 1, 0);
    drive(0, 0, 1, 1, 0, 0, 0, 1, 0);
    drive(0, 0, 1, 1, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 1, 1, 1, 0, 0, 0, 1, 0);
    drive(1, 0, 1, 1, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    // A fills the outstanding counter, then acks and accepts overlap
    drive(1, 1, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) drive(1, 1, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 1, 0, 0, 0, 1, 0, 1, 32'h1111_0001);
    drive(1, 1, 0, 0, 0, 1, 0, 1, 32'h1111_0002);
    drive(1, 1, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 1, 0, 1, 32'h1111_0003);
    // A aborts with transfers in flight while B waits; late ack goes nowhere
    drive(1, 0, 1, 1, 0, 0, 0, 1, 0);
    drive(0, 0, 1, 1, 0, 1, 0, 1, 32'h2222_0000);
    drive(0, 0, 1, 1, 0, 0, 0, 1, 0);
    drive(0, 0, 1, 1, 0, 0, 0, 1, 0);
    drive(0, 0, 1, 1, 0, 0, 0, 1, 0);
    // bus error clears B's count, then reset mid-cycle
    drive(0, 0, 1, 0, 0, 0, 1, 1, 32'h3333_0000);
    drive(0, 0, 1, 1, 0, 0, 0, 1, 0);
    drive(0, 0, 1, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 1, 0, 1, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);

    ac = 1'b0;
    bc = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      ph = i / 750;
      ac = ac ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 2) == 0);
      bc = bc ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 2) == 0);
      as = ac && ($urandom_range(0, 1) == 1);
      bs = bc && ($urandom_range(0, 1) == 1);
      ms = ($urandom_range(0, 3) < ph);
      mk = ($urandom_range(0, 2) == 0);
      me = ($urandom_range(0, 40) == 0);
      rn = ($urandom_range(0, 300) != 0);
      drive(ac, as, bc, bs, ms, mk, me, rn, $urandom);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
